// File: rtl/sdf_pkg.sv
// -----------------------------------------------------------------------------
// sdf_pkg
// Shared types and constants for the SDF delay-line sequencer.
//   sdf_state_e  : sequencer state (PRIME while the prefetch pipe fills, RUN after)
//   MIN_DEPTH    : smallest legal delay; keeps read and write slots apart
//   FIFO_DEPTH   : prefetch FIFO capacity (stored entries + reads in flight)
//   clamp_depth  : folds an illegal requested depth into MIN_DEPTH..max_depth
// -----------------------------------------------------------------------------
package sdf_pkg;

   typedef enum logic {
      ST_PRIME = 1'b0,
      ST_RUN   = 1'b1
   } sdf_state_e;

   localparam int MIN_DEPTH  = 4;
   localparam int FIFO_DEPTH = 2;

   function automatic logic [15:0] clamp_depth(input logic [15:0] req,
                                               input logic [15:0] max_depth);
      logic [15:0] res;
      res = req;
      if (req < 16'(MIN_DEPTH)) begin
         res = 16'(MIN_DEPTH);
      end else if (req > max_depth) begin
         res = max_depth;
      end
      return res;
   endfunction

endpackage

// File: rtl/sdf_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// sdf_prefetch_fifo
// Two-entry register FIFO holding SRAM read data fetched ahead of use.
// The SRAM returns data one cycle after a read is issued; that outstanding
// read is tracked here so the owner sees a single occupancy figure.
// Ports:
//   i_clock, i_reset_n : clock, asynchronous active-low reset
//   i_clear            : flush stored entries and drop any read in flight
//   i_issue            : a read is being issued to the SRAM this cycle
//   i_pop              : consume the head entry this cycle
//   i_rdata            : SRAM read data (valid the cycle after i_issue)
//   o_head             : head entry, registered
//   o_nonempty         : at least one stored entry
//   o_push             : read data lands in the FIFO at the end of this cycle
//   o_occupancy        : stored entries + reads in flight
// -----------------------------------------------------------------------------
module sdf_prefetch_fifo #(
   parameter int DATA_W = 32
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic              i_clear,
   input  logic              i_issue,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_rdata,
   output logic [DATA_W-1:0] o_head,
   output logic              o_nonempty,
   output logic              o_push,
   output logic [1:0]        o_occupancy
);

   logic [DATA_W-1:0] r_head;
   logic [DATA_W-1:0] r_tail;
   logic [1:0]        r_count;
   // Set for the cycle in which issued read data is on i_rdata. Clearing it
   // on a flush marks that read stale, so its data is never stored.
   logic              r_inflight;

   assign o_head      = r_head;
   assign o_nonempty  = (r_count != 2'd0);
   assign o_push      = r_inflight;
   assign o_occupancy = r_count + {1'b0, r_inflight};

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= 2'd0;
         r_inflight <= 1'b0;
      end else if (i_clear) begin
         r_count    <= 2'd0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= i_issue;
         // The owner never lets occupancy exceed two, so a push without a
         // pop only happens with at most one stored entry.
         case ({r_inflight, i_pop})
            2'b10: begin
               if (r_count == 2'd0) r_head <= i_rdata;
               else                 r_tail <= i_rdata;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_head  <= r_tail;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_head <= i_rdata;
               end else begin
                  r_head <= r_tail;
                  r_tail <= i_rdata;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/sdf_delay_line_ctrl.sv
// -----------------------------------------------------------------------------
// sdf_delay_line_ctrl
// Sequencer for one SRAM-backed SDF delay line. Each accepted input sample is
// written to slot wp of a 1R1W SRAM; the sample written depth accepts earlier
// is read ahead into a small prefetch FIFO and presented on the output in
// lock-step with the accept, sustaining one sample per cycle.
// Ports:
//   i_clock, i_reset_n        : clock, asynchronous active-low reset
//   i_cfg_depth, i_cfg_load   : new delay length, latched (clamped) on load;
//                               load also flushes and restarts the line
//   i_in_valid/o_in_ready     : input handshake, i_in_data sample
//   o_out_valid/i_out_ready   : delayed-sample handshake, o_out_data sample
//   o_primed                  : depth samples written since last restart
//   o_mem_raddr/o_mem_ren     : SRAM read port, i_mem_rdata one cycle later
//   o_mem_waddr/o_mem_wen/o_mem_wdata : SRAM write port
//   o_dbg_state               : current sequencer state
// Handshake: a transfer happens on a cycle where valid && ready. o_in_ready
// never looks at i_in_valid; o_out_valid does look at i_in_valid (input and
// output transfer together once primed), and i_out_ready feeds only
// o_in_ready, so there is no combinational loop through the two handshakes.
// -----------------------------------------------------------------------------
module sdf_delay_line_ctrl
   import sdf_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 7,
   parameter int RST_DEPTH = 128
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic [ADDR_W:0]   i_cfg_depth,
   input  logic              i_cfg_load,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_primed,
   output logic [ADDR_W-1:0] o_mem_raddr,
   output logic              o_mem_ren,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic [ADDR_W-1:0] o_mem_waddr,
   output logic              o_mem_wen,
   output logic [DATA_W-1:0] o_mem_wdata,
   output sdf_state_e        o_dbg_state
);

   localparam int              DW           = ADDR_W + 1;
   localparam logic [15:0]     MAX_DEPTH_16 = 16'(1 << ADDR_W);
   localparam logic [DW-1:0]   RST_DEPTH_C  = DW'(clamp_depth(16'(RST_DEPTH), MAX_DEPTH_16));

   sdf_state_e        r_state;
   sdf_state_e        w_state_nxt;
   logic [DW-1:0]     r_depth;
   logic [ADDR_W-1:0] r_wp;
   logic [ADDR_W-1:0] r_rp;
   logic              r_primed;
   // Low only in the first cycle out of reset, so the read port stays idle
   // while reset is asserted even though the state is already PRIME.
   logic              r_live;

   logic [DATA_W-1:0] w_head;
   logic              w_fifo_nonempty;
   logic              w_fifo_push;
   logic [1:0]        w_occ;
   logic              w_in_ready;
   logic              w_out_valid;
   logic              w_accept;
   logic              w_issue;
   logic              w_wp_last;
   logic              w_rp_last;

   assign w_wp_last = ({1'b0, r_wp} == (r_depth - DW'(1)));
   assign w_rp_last = ({1'b0, r_rp} == (r_depth - DW'(1)));

   sdf_prefetch_fifo #(
      .DATA_W (DATA_W)
   ) u_prefetch (
      .i_clock     (i_clock),
      .i_reset_n   (i_reset_n),
      .i_clear     (i_cfg_load),
      .i_issue     (w_issue),
      .i_pop       (w_accept),
      .i_rdata     (i_mem_rdata),
      .o_head      (w_head),
      .o_nonempty  (w_fifo_nonempty),
      .o_push      (w_fifo_push),
      .o_occupancy (w_occ)
   );

   // State register
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= ST_PRIME;
      else            r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      if (i_cfg_load) begin
         w_state_nxt = ST_PRIME;
      end else begin
         case (r_state)
            ST_PRIME: if (w_fifo_nonempty || w_fifo_push) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_PRIME;
         endcase
      end
   end

   // Output / handshake logic
   always_comb begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_issue     = 1'b0;
      if ((r_state == ST_RUN) && w_fifo_nonempty && !i_cfg_load) begin
         w_in_ready  = !r_primed || i_out_ready;
         w_out_valid = r_primed && i_in_valid;
      end
      w_accept = w_in_ready && i_in_valid;
      // rp - wp always equals the occupancy, so capping it at two keeps the
      // read slot one or two ahead of the write slot; with depth >= 4 the
      // two ports never address the same slot in the same cycle.
      if (r_live && !i_cfg_load) begin
         w_issue = (w_occ < 2'(FIFO_DEPTH)) ||
                   ((w_occ == 2'(FIFO_DEPTH)) && w_accept);
      end
   end

   // Pointers, depth and priming
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_depth  <= RST_DEPTH_C;
         r_wp     <= '0;
         r_rp     <= '0;
         r_primed <= 1'b0;
         r_live   <= 1'b0;
      end else begin
         r_live <= 1'b1;
         if (i_cfg_load) begin
            r_depth  <= DW'(clamp_depth(16'(i_cfg_depth), MAX_DEPTH_16));
            r_wp     <= '0;
            r_rp     <= '0;
            r_primed <= 1'b0;
         end else begin
            if (w_accept) begin
               r_wp <= w_wp_last ? '0 : r_wp + ADDR_W'(1);
               if (w_wp_last) r_primed <= 1'b1;
            end
            if (w_issue) begin
               r_rp <= w_rp_last ? '0 : r_rp + ADDR_W'(1);
            end
         end
      end
   end

   assign o_in_ready  = w_in_ready;
   assign o_out_valid = w_out_valid;
   assign o_out_data  = w_head;
   assign o_primed    = r_primed;
   assign o_mem_ren   = w_issue;
   assign o_mem_raddr = r_rp;
   assign o_mem_wen   = w_accept;
   assign o_mem_waddr = r_wp;
   assign o_mem_wdata = i_in_data;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sdf_delay_line_ctrl.sv
module tb_sdf_delay_line_ctrl;
  import sdf_pkg::*;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 7;
  localparam int CW        = ADDR_W + 1;
  localparam int RST_DEPTH = 128;
  localparam int NSLOT     = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [CW-1:0]     cfg_depth = '0;
  logic              cfg_load = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              o_in_ready, o_out_valid, o_primed, o_mem_ren, o_mem_wen;
  logic [DATA_W-1:0] o_out_data, o_mem_wdata;
  logic [ADDR_W-1:0] o_mem_raddr, o_mem_waddr;
  sdf_state_e        o_dbg_state;

  sdf_delay_line_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RST_DEPTH(RST_DEPTH)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_cfg_depth(cfg_depth), .i_cfg_load(cfg_load),
    .i_in_valid(in_valid), .o_in_ready(o_in_ready), .i_in_data(in_data),
    .o_out_valid(o_out_valid), .i_out_ready(out_ready), .o_out_data(o_out_data),
    .o_primed(o_primed), .o_mem_raddr(o_mem_raddr), .o_mem_ren(o_mem_ren),
    .i_mem_rdata(mem_rdata), .o_mem_waddr(o_mem_waddr), .o_mem_wen(o_mem_wen),
    .o_mem_wdata(o_mem_wdata), .o_dbg_state(o_dbg_state)
  );

  // 1R1W SRAM: read data valid the cycle after the read enable
  logic [DATA_W-1:0] sram [NSLOT];
  always @(posedge clk) begin
    if (o_mem_wen) sram[o_mem_waddr] <= o_mem_wdata;
    if (o_mem_ren) mem_rdata <= sram[o_mem_raddr];
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampd(input int d);
    if (d < 4) return 4;
    if (d > NSLOT) return NSLOT;
    return d;
  endfunction

  // Reference model: every accepted input since the last restart, in order.
  // The output paired with accept number n (0-based) is hist[n - depth].
  logic [DATA_W-1:0] hist[$];
  logic [DATA_W-1:0] got_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int mdepth = RST_DEPTH;
  bit mon_prim, mon_acc, mon_fire;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", o_in_ready, 0);
      chk("rst_out_valid", o_out_valid, 0);
      chk("rst_primed", o_primed, 0);
      chk("rst_ren", o_mem_ren, 0);
      chk("rst_wen", o_mem_wen, 0);
      chk("rst_raddr", o_mem_raddr, 0);
      chk("rst_waddr", o_mem_waddr, 0);
      hist.delete();
      mdepth = RST_DEPTH;
    end else begin
      chk("no_collision", o_mem_ren && o_mem_wen && (o_mem_raddr == o_mem_waddr), 0);
      mon_prim = (hist.size() >= mdepth);
      chk("primed", o_primed, mon_prim);
      if (cfg_load) begin
        chk("load_no_accept", o_in_ready, 0);
        chk("load_no_out", o_out_valid, 0);
        chk("load_no_wen", o_mem_wen, 0);
        hist.delete();
        mdepth = clampd(int'(cfg_depth));
      end else begin
        mon_acc  = in_valid && o_in_ready;
        mon_fire = o_out_valid && out_ready;
        chk("xfer_pair", mon_fire, mon_acc && mon_prim);
        if (!mon_prim || !in_valid) chk("out_valid_qual", o_out_valid, 0);
        else if (o_out_valid) chk("out_data", o_out_data, hist[hist.size() - mdepth]);
        chk("wen_is_accept", o_mem_wen, mon_acc);
        if (mon_acc) begin
          chk("wdata", o_mem_wdata, in_data);
          hist.push_back(in_data);
        end
        if (mon_fire) got_q.push_back(o_out_data);
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic push_one(input logic [DATA_W-1:0] d, output int waits);
    waits = 0;
    in_valid = 1'b1;
    in_data = d;
    @(negedge clk);
    while (!o_in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    chk("accept_wait", o_in_ready, 1);
    if (o_in_ready) exp_q.push_back(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_load(input int d);
    cfg_load = 1'b1;
    cfg_depth = CW'(d);
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("load_in_ready", o_in_ready, 0);
    @(posedge clk); #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("load_primed", o_primed, 0);
    chk("load_state", o_dbg_state, ST_PRIME);
    @(posedge clk); #1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic run_random(input int cycles, input int ready_pct);
    for (int c = 0; c < cycles; c++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_data = $urandom;
      out_ready = ($urandom_range(0, 99) < ready_pct);
      @(negedge clk);
      if (in_valid && o_in_ready) exp_q.push_back(in_data);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // outputs seen must be exactly the accepted inputs delayed by depth accepts
  task automatic check_stream(input string tag, input int depth);
    int n_exp;
    n_exp = (exp_q.size() > depth) ? exp_q.size() - depth : 0;
    chk({tag, "_count"}, got_q.size(), n_exp);
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++)
      chk({tag, "_data"}, got_q[j], exp_q[j]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int stall_sum;
    int next_d;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_data", o_out_data, 0);
    chk("rst_state", o_dbg_state, ST_PRIME);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // default depth 128, 300 ramp samples back-to-back
    got_q.delete(); exp_q.delete();
    stall_sum = 0;
    for (int i = 0; i < 300; i++) begin
      push_one(DATA_W'(i), w);
      if (i > 0) stall_sum += w;
    end
    idle(4);
    chk("t3_no_bubble", stall_sum, 0);
    check_stream("t3", 128);

    // depth 4, samples 1..12 back-to-back
    do_load(4);
    for (int i = 1; i <= 12; i++) push_one(DATA_W'(i), w);
    idle(4);
    check_stream("t1", 4);

    // depth 4, out_ready toggling after priming
    do_load(4);
    for (int i = 100; i < 104; i++) push_one(DATA_W'(i), w);
    next_d = 104;
    for (int c = 0; c < 32; c++) begin
      out_ready = c[0];
      in_valid = 1'b1;
      in_data = DATA_W'(next_d);
      @(negedge clk);
      chk("t2_ready_follows", o_in_ready, out_ready);
      if (o_in_ready) begin
        exp_q.push_back(in_data);
        next_d++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(4);
    check_stream("t2", 4);

    // mid-stream reload with depth 5
    for (int i = 0; i < 6; i++) push_one($urandom, w);
    do_load(5);
    for (int i = 1; i <= 10; i++) push_one(DATA_W'(i), w);
    idle(4);
    check_stream("t4", 5);

    // reset in the middle of RUN
    for (int i = 0; i < 3; i++) push_one($urandom, w);
    in_valid = 1'b1;
    in_data = 32'h1234_5678;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", o_in_ready, 0);
    chk("midrst_out_valid", o_out_valid, 0);
    chk("midrst_primed", o_primed, 0);
    chk("midrst_ren", o_mem_ren, 0);
    chk("midrst_wen", o_mem_wen, 0);
    chk("midrst_waddr", o_mem_waddr, 0);
    chk("midrst_raddr", o_mem_raddr, 0);
    chk("midrst_out_data", o_out_data, 0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 130; i++) push_one($urandom, w);
    idle(4);
    check_stream("t5", 128);

    // clamping of illegal depths under random traffic
    do_load(1);
    run_random(120, 70);
    idle(4);
    check_stream("clamp_lo", 4);
    do_load(200);
    run_random(400, 80);
    idle(4);
    check_stream("clamp_hi", 128);

    // random depths, random valid/ready
    for (int k = 0; k < 3; k++) begin
      int d;
      d = $urandom_range(4, 40);
      do_load(d);
      run_random(300, 60);
      idle(4);
      check_stream("rand", d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
